// File: rtl/spi_slave_bus_monitor.sv
// spi_slave_bus_monitor: passive SPI bus monitor that captures MOSI/MISO words
// for one selected slave and queues them in a small capture FIFO.
// Optional feature: define SPI_MON_XFER_COUNTERS_EN to add the word_count and
// partial_count transfer counters.
module spi_slave_bus_monitor #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NO_OF_SLAVES = 1,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned IDX_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1,
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1)
) (
    input  logic                    pclk,
    input  logic                    areset,
    input  logic                    sclk,
    input  logic [NO_OF_SLAVES-1:0] cs,
    input  logic                    mosi,
    input  logic                    miso,
    input  logic                    cfg_cpol,
    input  logic                    cfg_cpha,
    input  logic                    cfg_msb_first,
    input  logic                    clr_status,
    output logic                    mon_valid,
    input  logic                    mon_ready,
    output logic [DATA_WIDTH-1:0]   mon_mosi_data,
    output logic [DATA_WIDTH-1:0]   mon_miso_data,
    output logic [IDX_W-1:0]        mon_cs_index,
    output logic                    mon_partial,
    output logic [CNT_W-1:0]        mon_bit_count,
    output logic                    overflow,
    output logic                    cs_conflict,
`ifdef SPI_MON_XFER_COUNTERS_EN
    output logic [15:0]             word_count,
    output logic [15:0]             partial_count,
`endif
    output logic                    busy
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned LC_W   = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] mosi;
        logic [DATA_WIDTH-1:0] miso;
        logic [IDX_W-1:0]      idx;
        logic                  partial;
        logic [CNT_W-1:0]      cnt;
    } entry_t;

    // Synchroniser and edge-detect state
    logic                    sclk_s1, sclk_s2, sclk_d;
    logic                    mosi_s1, mosi_s2;
    logic                    miso_s1, miso_s2;
    logic [NO_OF_SLAVES-1:0] cs_s1, cs_s2;
    logic [1:0]              settle_cnt;

    // Capture state
    state_t                  state;
    logic                    armed;
    logic [IDX_W-1:0]        active_idx;
    logic                    cpol_q, cpha_q, msb_q;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   mosi_sh, miso_sh;
    logic                    pend_valid;
    entry_t                  pend;

    // FIFO state
    entry_t                  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]       fcnt;

    // Combinational decode
    logic                    settled_c;
    logic [LC_W-1:0]         low_cnt_c;
    logic [IDX_W-1:0]        low_idx_c;
    logic                    one_low_c, multi_low_c, all_high_c;
    logic                    act_high_c;
    logic                    rise_c, fall_c, sample_c;
    logic [DATA_WIDTH-1:0]   mosi_next_c, miso_next_c;
    logic [CNT_W-1:0]        shamt_c;
    entry_t                  full_entry_c, partial_entry_c;
    logic                    full_c, do_pop_c, do_push_c, ovf_evt_c, conflict_evt_c;
    logic [FCNT_W-1:0]       fcnt_next_c;
    entry_t                  head_c;

    // Two-flop synchronisers plus a delayed sclk copy for edge detection
    always_ff @(posedge pclk) begin
        if (!areset) begin
            sclk_s1    <= 1'b0;
            sclk_s2    <= 1'b0;
            sclk_d     <= 1'b0;
            mosi_s1    <= 1'b0;
            mosi_s2    <= 1'b0;
            miso_s1    <= 1'b0;
            miso_s2    <= 1'b0;
            cs_s1      <= '1;
            cs_s2      <= '1;
            settle_cnt <= 2'd0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
            cs_s1   <= cs;
            cs_s2   <= cs_s1;
            if (settle_cnt != 2'd2) begin
                settle_cnt <= settle_cnt + 2'd1;
            end
        end
    end

    // Chip-select decode: how many lines are low, which one, and the active line level
    always_comb begin
        low_cnt_c  = '0;
        low_idx_c  = '0;
        act_high_c = 1'b1;
        for (int i = 0; i < int'(NO_OF_SLAVES); i++) begin
            if (!cs_s2[i]) begin
                low_cnt_c = low_cnt_c + LC_W'(1);
                low_idx_c = IDX_W'(i);
            end
            if (IDX_W'(i) == active_idx) begin
                act_high_c = cs_s2[i];
            end
        end
        settled_c   = (settle_cnt == 2'd2);
        one_low_c   = (low_cnt_c == LC_W'(1));
        multi_low_c = (low_cnt_c > LC_W'(1));
        all_high_c  = (low_cnt_c == LC_W'(0));
    end

    // Sample-edge selection, shift update and candidate FIFO entries
    always_comb begin
        rise_c   = sclk_s2 & ~sclk_d;
        fall_c   = ~sclk_s2 & sclk_d;
        sample_c = (cpol_q == cpha_q) ? rise_c : fall_c;
        if (msb_q) begin
            mosi_next_c = {mosi_sh[DATA_WIDTH-2:0], mosi_s2};
            miso_next_c = {miso_sh[DATA_WIDTH-2:0], miso_s2};
        end else begin
            mosi_next_c = {mosi_s2, mosi_sh[DATA_WIDTH-1:1]};
            miso_next_c = {miso_s2, miso_sh[DATA_WIDTH-1:1]};
        end
        shamt_c = CNT_W'(DATA_WIDTH) - bit_cnt;

        full_entry_c.mosi    = mosi_next_c;
        full_entry_c.miso    = miso_next_c;
        full_entry_c.idx     = active_idx;
        full_entry_c.partial = 1'b0;
        full_entry_c.cnt     = CNT_W'(DATA_WIDTH);

        // LSB-first words fill from the top, so short words are shifted down to bit 0
        partial_entry_c.mosi    = msb_q ? mosi_sh : (mosi_sh >> shamt_c);
        partial_entry_c.miso    = msb_q ? miso_sh : (miso_sh >> shamt_c);
        partial_entry_c.idx     = active_idx;
        partial_entry_c.partial = 1'b1;
        partial_entry_c.cnt     = bit_cnt;
    end

    // Capture FSM: select a slave, shift bits, stage completed words for the FIFO
    always_ff @(posedge pclk) begin
        if (!areset) begin
            state      <= IDLE;
            armed      <= 1'b0;
            active_idx <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            msb_q      <= 1'b0;
            bit_cnt    <= '0;
            mosi_sh    <= '0;
            miso_sh    <= '0;
            pend_valid <= 1'b0;
            pend       <= '0;
        end else begin
            pend_valid <= 1'b0;
            if (settled_c && multi_low_c) begin
                // Bus contention: drop any partial word and wait for a clean idle bus
                state   <= IDLE;
                armed   <= 1'b0;
                bit_cnt <= '0;
                mosi_sh <= '0;
                miso_sh <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cpol_q <= cfg_cpol;
                        cpha_q <= cfg_cpha;
                        msb_q  <= cfg_msb_first;
                        if (settled_c && all_high_c) begin
                            armed <= 1'b1;
                        end
                        if (settled_c && armed && one_low_c) begin
                            state      <= ACTIVE;
                            active_idx <= low_idx_c;
                            armed      <= 1'b0;
                            bit_cnt    <= '0;
                            mosi_sh    <= '0;
                            miso_sh    <= '0;
                        end
                    end
                    ACTIVE: begin
                        if (act_high_c) begin
                            state   <= IDLE;
                            armed   <= all_high_c;
                            bit_cnt <= '0;
                            mosi_sh <= '0;
                            miso_sh <= '0;
                            if (bit_cnt != '0) begin
                                pend_valid <= 1'b1;
                                pend       <= partial_entry_c;
                            end
                        end else if (sample_c) begin
                            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                                pend_valid <= 1'b1;
                                pend       <= full_entry_c;
                                bit_cnt    <= '0;
                                mosi_sh    <= '0;
                                miso_sh    <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                                mosi_sh <= mosi_next_c;
                                miso_sh <= miso_next_c;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // FIFO handshake decode; a full FIFO still accepts a push when it is popped the same cycle
    always_comb begin
        full_c         = (fcnt == FCNT_W'(FIFO_DEPTH));
        do_pop_c       = mon_valid & mon_ready;
        do_push_c      = pend_valid & (~full_c | do_pop_c);
        ovf_evt_c      = pend_valid & full_c & ~do_pop_c;
        conflict_evt_c = settled_c & multi_low_c;
        case ({do_push_c, do_pop_c})
            2'b10:   fcnt_next_c = fcnt + FCNT_W'(1);
            2'b01:   fcnt_next_c = fcnt - FCNT_W'(1);
            default: fcnt_next_c = fcnt;
        endcase
    end

    // Capture FIFO storage and pointers
    always_ff @(posedge pclk) begin
        if (!areset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fcnt      <= '0;
            mon_valid <= 1'b0;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= pend;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fcnt      <= fcnt_next_c;
            mon_valid <= (fcnt_next_c != '0);
        end
    end

    // Sticky status flags; a new event outranks a clear in the same cycle
    always_ff @(posedge pclk) begin
        if (!areset) begin
            overflow    <= 1'b0;
            cs_conflict <= 1'b0;
        end else begin
            if (ovf_evt_c) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end
            if (conflict_evt_c) begin
                cs_conflict <= 1'b1;
            end else if (clr_status) begin
                cs_conflict <= 1'b0;
            end
        end
    end

`ifdef SPI_MON_XFER_COUNTERS_EN
    // Saturating counts of successfully queued full and partial words
    always_ff @(posedge pclk) begin
        if (!areset) begin
            word_count    <= 16'd0;
            partial_count <= 16'd0;
        end else begin
            if (do_push_c && !pend.partial) begin
                if (clr_status) begin
                    word_count <= 16'd1;
                end else if (word_count != 16'hFFFF) begin
                    word_count <= word_count + 16'd1;
                end
            end else if (clr_status) begin
                word_count <= 16'd0;
            end
            if (do_push_c && pend.partial) begin
                if (clr_status) begin
                    partial_count <= 16'd1;
                end else if (partial_count != 16'hFFFF) begin
                    partial_count <= partial_count + 16'd1;
                end
            end else if (clr_status) begin
                partial_count <= 16'd0;
            end
        end
    end
`endif

    // FIFO head is presented directly from storage; it only moves on a pop
    assign head_c        = mem[rd_ptr];
    assign mon_mosi_data = head_c.mosi;
    assign mon_miso_data = head_c.miso;
    assign mon_cs_index  = head_c.idx;
    assign mon_partial   = head_c.partial;
    assign mon_bit_count = head_c.cnt;
    assign busy          = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_bus_monitor.sv
// Bench for spi_slave_bus_monitor (DATA_WIDTH=8, NO_OF_SLAVES=4, FIFO_DEPTH=4).
module tb_spi_slave_bus_monitor;

    localparam int unsigned DW = 8;
    localparam int unsigned NS = 4;
    localparam int unsigned FD = 4;

    typedef struct packed {
        logic [7:0] mosi;
        logic [7:0] miso;
        logic [1:0] idx;
        logic       partial;
        logic [3:0] cnt;
    } ent_t;

    logic        pclk = 1'b0;
    logic        areset, sclk, mosi, miso;
    logic [3:0]  cs;
    logic        cfg_cpol, cfg_cpha, cfg_msb_first, clr_status, mon_ready;
    logic        mon_valid, mon_partial, overflow, cs_conflict, busy;
    logic [7:0]  mon_mosi_data, mon_miso_data;
    logic [1:0]  mon_cs_index;
    logic [3:0]  mon_bit_count;
`ifdef SPI_MON_XFER_COUNTERS_EN
    logic [15:0] word_count, partial_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    spi_slave_bus_monitor #(.DATA_WIDTH(DW), .NO_OF_SLAVES(NS), .FIFO_DEPTH(FD)) dut (
        .pclk(pclk), .areset(areset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_msb_first(cfg_msb_first),
        .clr_status(clr_status), .mon_valid(mon_valid), .mon_ready(mon_ready),
        .mon_mosi_data(mon_mosi_data), .mon_miso_data(mon_miso_data),
        .mon_cs_index(mon_cs_index), .mon_partial(mon_partial),
        .mon_bit_count(mon_bit_count), .overflow(overflow), .cs_conflict(cs_conflict),
`ifdef SPI_MON_XFER_COUNTERS_EN
        .word_count(word_count), .partial_count(partial_count),
`endif
        .busy(busy)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected word value from a bit sequence, by plain positional arithmetic
    function automatic logic [7:0] word_of(input bit q[$], input int s, input int n, input bit msb);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (msb) v = v | (8'(q[s+k]) << (n - 1 - k));
            else     v = v | (8'(q[s+k]) << k);
        end
        return v;
    endfunction

    // Half an SCLK period: 4 pclk cycles, pins change 1ns after a rising pclk edge
    task automatic half();
        repeat (4) @(posedge pclk);
        #1;
    endtask

    task automatic set_mode(input int mode, input bit msb);
        cfg_cpol      = mode[1];
        cfg_cpha      = mode[0];
        cfg_msb_first = msb;
        sclk          = mode[1];
        half();
    endtask

    task automatic cs_low(input int idx);
        cs      = 4'hF;
        cs[idx] = 1'b0;
        half();
    endtask

    task automatic cs_high();
        half();
        cs = 4'hF;
        half();
    endtask

    // Drive one bit, returning immediately after its sampling edge
    task automatic bit_to_sample(input bit m, input bit s);
        if (!cfg_cpha) begin
            mosi = m; miso = s;
            half();
            sclk = ~sclk;
        end else begin
            sclk = ~sclk;
            mosi = m; miso = s;
            half();
            sclk = ~sclk;
        end
    endtask

    task automatic bit_after();
        half();
        if (!cfg_cpha) sclk = ~sclk;
    endtask

    task automatic send_bits(input int idx, input bit mq[$], input bit sq[$]);
        cs_low(idx);
        for (int k = 0; k < mq.size(); k++) begin
            bit_to_sample(mq[k], sq[k]);
            bit_after();
        end
        cs_high();
    endtask

    // Full word up to (and including) its final sampling edge
    task automatic word_to_last(input int idx, input logic [7:0] mv, input logic [7:0] sv);
        cs_low(idx);
        for (int k = 0; k < 8; k++) begin
            if (cfg_msb_first) bit_to_sample(mv[7-k], sv[7-k]);
            else               bit_to_sample(mv[k], sv[k]);
            if (k < 7) bit_after();
        end
    endtask

    task automatic word_finish();
        if (!cfg_cpha) sclk = ~sclk;
        half();
        cs = 4'hF;
        half();
    endtask

    task automatic send_word(input int idx, input logic [7:0] mv, input logic [7:0] sv);
        word_to_last(idx, mv, sv);
        bit_after();
        cs_high();
    endtask

    // Pop the FIFO head (bounded wait); reports whether an entry appeared
    task automatic get_entry(output bit got, output ent_t e);
        got = 1'b0;
        e   = '0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge pclk);
            if (mon_valid) begin
                got = 1'b1;
                e   = {mon_mosi_data, mon_miso_data, mon_cs_index, mon_partial, mon_bit_count};
                mon_ready = 1'b1;
                @(posedge pclk);
                #1;
                mon_ready = 1'b0;
            end
        end
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        @(posedge pclk);
        #1;
        clr_status = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        repeat (3) @(posedge pclk);
        #1;
        obs = {mon_valid, mon_mosi_data, mon_miso_data, mon_cs_index, mon_partial,
               mon_bit_count, overflow, cs_conflict, busy};
        n_cmp++;
        if (obs !== 32'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h expected %h", obs, 32'h0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        areset = 1'b1;
        half();
        n_cmp++;
        if (mon_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_release_valid: got %b expected 0", mon_valid);
        end
    endtask

    task automatic test_basic();
        bit   got;
        ent_t e, x;
        set_mode(0, 1'b1);
        word_to_last(0, 8'hA5, 8'h3C);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_busy: got %b expected 1", busy);
        end
        repeat (3) @(posedge pclk);
        #1;
        n_cmp++;
        if (mon_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_latency_early: got %b expected 0", mon_valid);
        end
        @(posedge pclk);
        #1;
        n_cmp++;
        if (mon_valid !== 1'b1) begin
            n_bad++; $display("FAIL basic_latency_4: got %b expected 1", mon_valid);
        end
        word_finish();
        get_entry(got, e);
        x = '{mosi: 8'hA5, miso: 8'h3C, idx: 2'd0, partial: 1'b0, cnt: 4'd8};
        n_cmp++;
        if (!got || e !== x) begin
            n_bad++; $display("FAIL basic_entry: got %h (seen %b) expected %h", e, got, x);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_lsb_partial();
        bit   mq[$], sq[$];
        bit   got;
        ent_t e, x;
        logic [4:0] pat;
        pat = 5'b01101;
        for (int k = 0; k < 5; k++) begin
            mq.push_back(pat[k]);
            sq.push_back(1'($urandom_range(0, 1)));
        end
        set_mode(3, 1'b0);
        send_bits(0, mq, sq);
        get_entry(got, e);
        x = '{mosi: 8'h0D, miso: word_of(sq, 0, 5, 1'b0), idx: 2'd0, partial: 1'b1, cnt: 4'd5};
        n_cmp++;
        if (!got || e !== x) begin
            n_bad++; $display("FAIL lsb_partial_entry: got %h (seen %b) expected %h", e, got, x);
        end
    endtask

    task automatic test_overflow();
        ent_t exp_q[$];
        ent_t e;
        bit   got;
        logic [7:0] mv, sv;
        set_mode(0, 1'b1);
        for (int w = 0; w < 6; w++) begin
            mv = 8'($urandom);
            sv = 8'($urandom);
            if (w < 4) exp_q.push_back('{mosi: mv, miso: sv, idx: 2'd1, partial: 1'b0, cnt: 4'd8});
            send_word(1, mv, sv);
        end
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++; $display("FAIL overflow_set: got %b expected 1", overflow);
        end
        for (int w = 0; w < 4; w++) begin
            get_entry(got, e);
            n_cmp++;
            if (!got || e !== exp_q[w]) begin
                n_bad++; $display("FAIL overflow_entry%0d: got %h (seen %b) expected %h", w, e, got, exp_q[w]);
            end
        end
        repeat (10) @(posedge pclk);
        #1;
        n_cmp++;
        if (mon_valid !== 1'b0) begin
            n_bad++; $display("FAIL overflow_dropped: got valid %b expected 0", mon_valid);
        end
        pulse_clr();
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL overflow_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        ent_t exp_q[$];
        ent_t e;
        bit   got;
        logic [7:0] mv, sv;
        set_mode(0, 1'b1);
        for (int w = 0; w < 5; w++) begin
            mv = 8'($urandom);
            sv = 8'($urandom);
            if (w > 0) exp_q.push_back('{mosi: mv, miso: sv, idx: 2'd3, partial: 1'b0, cnt: 4'd8});
            if (w < 4) begin
                send_word(3, mv, sv);
            end else begin
                word_to_last(3, mv, sv);
                repeat (3) @(posedge pclk);
                #1;
                mon_ready = 1'b1;
                @(posedge pclk);
                #1;
                mon_ready = 1'b0;
                word_finish();
            end
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL full_push_pop_overflow: got %b expected 0", overflow);
        end
        for (int w = 0; w < 4; w++) begin
            get_entry(got, e);
            n_cmp++;
            if (!got || e !== exp_q[w]) begin
                n_bad++; $display("FAIL full_push_pop_entry%0d: got %h (seen %b) expected %h", w, e, got, exp_q[w]);
            end
        end
    endtask

    task automatic test_conflict();
        bit   got;
        ent_t e, x;
        set_mode(0, 1'b1);
        cs_low(0);
        for (int k = 0; k < 3; k++) begin
            bit_to_sample(1'b1, 1'b0);
            bit_after();
        end
        cs = 4'b1010;
        half();
        n_cmp++;
        if (cs_conflict !== 1'b1) begin
            n_bad++; $display("FAIL conflict_set: got %b expected 1", cs_conflict);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL conflict_busy: got %b expected 0", busy);
        end
        for (int k = 0; k < 5; k++) begin
            bit_to_sample(1'b0, 1'b1);
            bit_after();
        end
        cs_high();
        half();
        n_cmp++;
        if (mon_valid !== 1'b0) begin
            n_bad++; $display("FAIL conflict_no_entry: got valid %b expected 0", mon_valid);
        end
        n_cmp++;
        if (cs_conflict !== 1'b1) begin
            n_bad++; $display("FAIL conflict_sticky: got %b expected 1", cs_conflict);
        end
        send_word(2, 8'h5E, 8'hC1);
        get_entry(got, e);
        x = '{mosi: 8'h5E, miso: 8'hC1, idx: 2'd2, partial: 1'b0, cnt: 4'd8};
        n_cmp++;
        if (!got || e !== x) begin
            n_bad++; $display("FAIL conflict_clean_entry: got %h (seen %b) expected %h", e, got, x);
        end
        pulse_clr();
        n_cmp++;
        if (cs_conflict !== 1'b0) begin
            n_bad++; $display("FAIL conflict_clear: got %b expected 0", cs_conflict);
        end
    endtask

    task automatic test_reset_mid();
        bit   got;
        ent_t e, x;
        set_mode(0, 1'b1);
        cs_low(1);
        for (int k = 0; k < 3; k++) begin
            bit_to_sample(1'b1, 1'b1);
            bit_after();
        end
        areset = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        areset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bit_to_sample(k[0], 1'b1);
            bit_after();
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_busy: got %b expected 0", busy);
        end
        cs_high();
        half();
        n_cmp++;
        if (mon_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_no_entry: got valid %b expected 0", mon_valid);
        end
        send_word(1, 8'h96, 8'h0F);
        get_entry(got, e);
        x = '{mosi: 8'h96, miso: 8'h0F, idx: 2'd1, partial: 1'b0, cnt: 4'd8};
        n_cmp++;
        if (!got || e !== x) begin
            n_bad++; $display("FAIL reset_mid_entry: got %h (seen %b) expected %h", e, got, x);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 14; t++) begin
            bit   mq[$], sq[$];
            ent_t exp_q[$];
            ent_t e;
            bit   got, msb;
            int   mode, idx, n, s;
            mode = int'($urandom_range(0, 3));
            msb  = 1'($urandom_range(0, 1));
            idx  = int'($urandom_range(0, 3));
            n    = int'($urandom_range(1, 20));
            for (int k = 0; k < n; k++) begin
                mq.push_back(1'($urandom_range(0, 1)));
                sq.push_back(1'($urandom_range(0, 1)));
            end
            s = 0;
            while (n - s >= 8) begin
                exp_q.push_back('{mosi: word_of(mq, s, 8, msb), miso: word_of(sq, s, 8, msb),
                                  idx: 2'(idx), partial: 1'b0, cnt: 4'd8});
                s += 8;
            end
            if (n - s > 0) begin
                exp_q.push_back('{mosi: word_of(mq, s, n - s, msb), miso: word_of(sq, s, n - s, msb),
                                  idx: 2'(idx), partial: 1'b1, cnt: 4'(n - s)});
            end
            set_mode(mode, msb);
            send_bits(idx, mq, sq);
            for (int w = 0; w < exp_q.size(); w++) begin
                get_entry(got, e);
                n_cmp++;
                if (!got || e !== exp_q[w]) begin
                    n_bad++;
                    $display("FAIL random_t%0d_e%0d (mode %0d msb %0d n %0d): got %h (seen %b) expected %h",
                             t, w, mode, msb, n, e, got, exp_q[w]);
                end
            end
        end
        repeat (10) @(posedge pclk);
        #1;
        n_cmp++;
        if (mon_valid !== 1'b0) begin
            n_bad++; $display("FAIL random_extra_entry: got valid %b expected 0", mon_valid);
        end
    endtask

`ifdef SPI_MON_XFER_COUNTERS_EN
    task automatic test_counters();
        bit   mq[$], sq[$];
        bit   got;
        ent_t e;
        pulse_clr();
        set_mode(0, 1'b1);
        for (int w = 0; w < 3; w++) send_word(0, 8'($urandom), 8'($urandom));
        for (int k = 0; k < 3; k++) begin
            mq.push_back(1'b1);
            sq.push_back(1'b0);
        end
        send_bits(0, mq, sq);
        n_cmp++;
        if (word_count !== 16'd3) begin
            n_bad++; $display("FAIL counters_word: got %0d expected 3", word_count);
        end
        n_cmp++;
        if (partial_count !== 16'd1) begin
            n_bad++; $display("FAIL counters_partial: got %0d expected 1", partial_count);
        end
        for (int w = 0; w < 4; w++) get_entry(got, e);
    endtask
`endif

    initial begin
        areset        = 1'b0;
        cs            = 4'hF;
        sclk          = 1'b0;
        mosi          = 1'b0;
        miso          = 1'b0;
        cfg_cpol      = 1'b0;
        cfg_cpha      = 1'b0;
        cfg_msb_first = 1'b1;
        clr_status    = 1'b0;
        mon_ready     = 1'b0;
        test_reset();
        test_basic();
        test_lsb_partial();
        test_overflow();
        test_full_push_pop();
        test_conflict();
        test_reset_mid();
        test_random();
`ifdef SPI_MON_XFER_COUNTERS_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
